// File: rtl/aes_shiftrows_col_feeder_if.sv
// Bus between the ShiftRows column feeder, its state source (in_*) and the column mixer (col_*).
// The slave modport is the feeder's view; the master modport is the surrounding datapath's view.
interface aes_shiftrows_col_feeder_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_state;
  logic         in_last_round;
  logic         col_valid;
  logic         col_ready;
  logic [0:31]  col_data;
  logic [1:0]   col_idx;
  logic         col_first;
  logic         col_last;
  logic         col_bypass;

  modport slave (
    input  in_valid, in_state, in_last_round, col_ready,
    output in_ready, col_valid, col_data, col_idx, col_first, col_last, col_bypass
  );

  modport master (
    output in_valid, in_state, in_last_round, col_ready,
    input  in_ready, col_valid, col_data, col_idx, col_first, col_last, col_bypass
  );
endinterface

// File: rtl/aes_shiftrows_col_feeder.sv
// ShiftRows applied at capture, then four 32-bit columns streamed to the mixer; first column one cycle
// after acceptance, columns held while col_ready is low, next state accepted on the column-3 handshake.
module aes_shiftrows_col_feeder #(
  parameter int OVERLAP = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  aes_shiftrows_col_feeder_if.slave    bus
);

  localparam logic OVL = (OVERLAP != 0);

  typedef enum logic {IDLE, SEND} state_t;

  state_t       st, st_nxt;
  logic [0:127] shifted_q;
  logic [0:127] shifted;
  logic [1:0]   idx_q;
  logic         byp_q;
  logic         col_hs;
  logic         last_hs;
  logic         load;

  // Row r of column c comes from input column (c+r) mod 4; stored column-major so column c is one word.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[32*c + 8*r +: 8] = bus.in_state[8*(4*((c + r) % 4) + r) +: 8];
      end
    end
  end

  always_comb begin
    col_hs  = (st == SEND) && bus.col_ready;
    last_hs = col_hs && (idx_q == 2'd3);
    bus.in_ready = rst_n && ((st == IDLE) || (OVL && last_hs));
    load    = bus.in_valid && bus.in_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: begin
        if (load) st_nxt = SEND;
      end
      SEND: begin
        if (last_hs) st_nxt = load ? SEND : IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // idx wraps 3->0 on the last handshake, so an idle feeder always shows column 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shifted_q <= '0;
      idx_q     <= 2'd0;
      byp_q     <= 1'b0;
    end else if (load) begin
      shifted_q <= shifted;
      idx_q     <= 2'd0;
      byp_q     <= bus.in_last_round;
    end else if (col_hs) begin
      idx_q     <= idx_q + 2'd1;
    end
  end

  always_comb begin
    bus.col_valid  = (st == SEND);
    bus.col_data   = shifted_q[32*idx_q +: 32];
    bus.col_idx    = idx_q;
    bus.col_first  = bus.col_valid && (idx_q == 2'd0);
    bus.col_last   = bus.col_valid && (idx_q == 2'd3);
    bus.col_bypass = byp_q;
  end

endmodule

// File: doc/aes_shiftrows_col_feeder.md
Name: aes_shiftrows_col_feeder

Overview:
- Stage directly upstream of the 32-bit column mixer in the AES encryption round datapath.
- Accepts one 128-bit post-SubBytes state per transaction over a valid/ready handshake.
- Applies ShiftRows at capture, then streams the four shifted columns, one per handshake, into the column mixer.
- Flags final-round blocks so downstream logic bypasses MixColumns.

Parameters:
- OVERLAP, 1: when 1, a new state may be accepted in the same cycle the current block's column 3 handshakes (back-to-back blocks). When 0, the block returns to IDLE for one cycle first.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream state valid
- in_ready  output  1  block can accept a state this cycle
- in_state  input  [0:127]  state, byte k = in_state[8k:8k+7], row k%4, column k/4 (column-major, MSB-first)
- in_last_round  input  1  state belongs to the final round
- col_valid  output  1  col_data valid
- col_ready  input  1  column mixer accepts col_data
- col_data  output  [0:31]  shifted column; [0:7]=row0 … [24:31]=row3
- col_idx  output  2  column number 0..3 of col_data
- col_first  output  1  col_idx==0
- col_last  output  1  col_idx==3
- col_bypass  output  1  registered in_last_round of the current block

Behaviour:
- All outputs are sampled on the clk rising edge.
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; col_valid=0, col_idx=0, col_bypass=0.
  - The state register clears to 0, so col_data=0.
  - in_ready=0 combinationally while rst_n=0.
- Reset mid-block drops the block; partial columns already sent are not recalled.
- ShiftRows at capture:
  - Stored S(r,c) = in_state byte (r, (c+r) mod 4).
  - Column c word = {S(0,c), S(1,c), S(2,c), S(3,c)}.
  - Pure byte permutation; no arithmetic.
- FSM states: IDLE, SEND.
- IDLE:
  - in_ready=1, col_valid=0.
  - On in_valid && in_ready: capture the shifted state and in_last_round, set col_idx=0, go to SEND.
  - The first column is presented the cycle after acceptance (1-cycle latency).
- SEND:
  - col_valid=1, col_data = column col_idx.
  - col_data, col_idx and col_bypass are held stable while col_valid && !col_ready.
  - col_ready=1 with col_idx<3: col_idx increments the next cycle.
  - col_ready=1 with col_idx==3 and OVERLAP=1: in_ready=1 combinationally this cycle.
    - If in_valid also =1: load the new block, set col_idx=0, stay in SEND (no bubble).
    - Otherwise: go to IDLE.
  - col_ready=1 with col_idx==3 and OVERLAP=0: go to IDLE.
  - In every other SEND case, in_ready=0.
- Throughput:
  - 4 cycles per block with OVERLAP=1 and col_ready held 1.
  - 5 cycles per block with OVERLAP=0.
- in_valid while in_ready=0 has no effect; upstream must hold its data until accepted.
- col_first and col_last decode col_idx and are qualified only by col_valid.
- The state is captured once per block; upstream may change in_state after acceptance without affecting the columns in flight.

Test Plan:
- FIPS-197 round 1: in_state=d42711ae e0bf98f1 b8b45de5 1e415230, col_ready=1 -> col_data sequence d4bf5d30, e0b452ae, b84111f1, 1e2798e5 with col_idx 0..3, col_first on column 0, col_last on column 3, col_bypass=0.
- Backpressure: same stimulus, col_ready=0 for 3 cycles at col_idx=1 -> col_data held at e0b452ae and col_idx at 1 until col_ready rises; all four columns in order, none duplicated.
- Back-to-back, OVERLAP=1: two states offered continuously, the second with in_last_round=1 -> 8 consecutive column handshakes with no bubble; in_ready pulses in the column-3 cycle of the first block; col_bypass=1 for the second block only.
- OVERLAP=0, same stimulus -> exactly one idle cycle (col_valid=0, in_ready=1) between the two blocks.
- Reset mid-block: rst_n=0 at col_idx=2 -> next cycle col_valid=0, col_idx=0, col_data=0, and in_ready=0 while rst_n low; after release, a new state streams correctly from column 0.
- Identity check: in_state=00 01 02 … 0f -> columns 00050a0f, 04090e03, 080d0207, 0c01060b.
